// File: rtl/summer_pkg.sv
// Shared constants for the summer accumulator tile: opcodes, flag pin
// positions and the bidirectional output-enable mask.
package summer_pkg;
  localparam int ACC_W = 16;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_LDLO = 3'b011;
  localparam logic [2:0] OP_LDHI = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_ADDS = 3'b110;

  localparam int FLAG_C = 4;
  localparam int FLAG_Z = 5;
  localparam int FLAG_N = 6;
  localparam int FLAG_V = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;
endpackage

// File: rtl/summer_alu.sv
// Combinational next-state logic for the accumulator: computes next acc and
// the C/V values, plus a strobe saying whether C/V should be written.
module summer_alu
  import summer_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [7:0]       x,
  input  logic [2:0]       opcode,
  output logic [ACC_W-1:0] next_acc,
  output logic             next_c,
  output logic             next_v,
  output logic             flag_upd
);
  logic [ACC_W:0]   res;
  logic [ACC_W-1:0] opnd;

  always_comb begin
    next_acc = acc;
    next_c   = 1'b0;
    next_v   = 1'b0;
    flag_upd = 1'b0;
    res      = '0;
    opnd     = (opcode == OP_ADDS) ? {{8{x[7]}}, x} : {8'h00, x};
    case (opcode)
      OP_ADD, OP_ADDS: begin
        res      = {1'b0, acc} + {1'b0, opnd};
        next_acc = res[ACC_W-1:0];
        next_c   = res[ACC_W];
        next_v   = (acc[ACC_W-1] == opnd[ACC_W-1]) && (res[ACC_W-1] != acc[ACC_W-1]);
        flag_upd = 1'b1;
      end
      OP_SUB: begin
        // 17-bit subtract: the top bit is the borrow (operand > acc unsigned)
        res      = {1'b0, acc} - {1'b0, opnd};
        next_acc = res[ACC_W-1:0];
        next_c   = res[ACC_W];
        next_v   = (acc[ACC_W-1] != opnd[ACC_W-1]) && (res[ACC_W-1] != acc[ACC_W-1]);
        flag_upd = 1'b1;
      end
      OP_LDLO: next_acc = {8'h00, x};
      OP_LDHI: next_acc = {x, acc[7:0]};
      OP_CLR: begin
        next_acc = '0;
        flag_upd = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/tt_um_summer_tiny_tapeout.sv
// Tiny Tapeout tile: 16-bit accumulator with C/Z/N/V flags. rst_n keeps its
// harness name but is an active-high asynchronous reset.
module tt_um_summer_tiny_tapeout
  import summer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [ACC_W-1:0] acc, next_acc;
  logic             c_q, v_q, next_c, next_v, flag_upd;
  logic             unused_uio;

  assign unused_uio = &{1'b0, uio_in[7:4]};

  summer_alu u_alu (
    .acc      (acc),
    .x        (ui_in),
    .opcode   (uio_in[2:0]),
    .next_acc (next_acc),
    .next_c   (next_c),
    .next_v   (next_v),
    .flag_upd (flag_upd)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (ena) begin
      acc <= next_acc;
      if (flag_upd) begin
        c_q <= next_c;
        v_q <= next_v;
      end
    end
  end

  always_comb begin
    uio_out         = 8'h00;
    uio_out[FLAG_C] = c_q;
    uio_out[FLAG_Z] = (acc == '0);
    uio_out[FLAG_N] = acc[ACC_W-1];
    uio_out[FLAG_V] = v_q;
  end

  assign uo_out = uio_in[3] ? acc[15:8] : acc[7:0];
  assign uio_oe = UIO_OE_MASK;
endmodule

// File: tb/tb_tt_um_summer_tiny_tapeout.sv
// Self-checking bench: a behavioural model pushes expected {V,C,acc} per
// driven cycle; each test pops and compares both bytes and the flag pins.
module tb_tt_um_summer_tiny_tapeout;
  logic       clk = 1'b0, clk_run = 1'b0;
  logic       rst_n = 1'b0, ena = 1'b0;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0, errors = 0;
  logic [15:0] m_acc = 16'h0;
  logic        m_c = 1'b0, m_v = 1'b0;
  logic [17:0] sb[$];
  logic [17:0] e;

  tt_um_summer_tiny_tapeout dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 if (clk_run) clk = ~clk;

  function automatic logic [7:0] exp_flags(input logic [17:0] s);
    return {s[17], s[15], (s[15:0] == 16'h0), s[16], 4'h0};
  endfunction

  // Independent reference: signed/unsigned integer arithmetic
  task automatic model(input logic [2:0] op, input logic [7:0] x);
    int a, ua, xs, xu, s;
    logic [31:0] t;
    a = int'($signed(m_acc)); ua = m_acc; xs = int'($signed(x)); xu = x;
    case (op)
      3'd1: begin s = a + xu; m_c = (ua + xu) > 65535;
              m_v = (s > 32767) || (s < -32768); t = s; m_acc = t[15:0]; end
      3'd2: begin s = a - xu; m_c = xu > ua;
              m_v = (s > 32767) || (s < -32768); t = s; m_acc = t[15:0]; end
      3'd6: begin s = a + xs; m_c = (ua + (xs & 32'hFFFF)) > 65535;
              m_v = (s > 32767) || (s < -32768); t = s; m_acc = t[15:0]; end
      3'd3: m_acc = {8'h00, x};
      3'd4: m_acc = {x, m_acc[7:0]};
      3'd5: begin m_acc = 16'h0; m_c = 1'b0; m_v = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] x,
                       input logic en, input logic r);
    @(negedge clk);
    uio_in = {5'b0, op}; ui_in = x; ena = en; rst_n = r;
    if (r) begin m_acc = 16'h0; m_c = 1'b0; m_v = 1'b0; end
    else if (en) model(op, x);
    sb.push_back({m_v, m_c, m_acc});
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b1; uio_in = 8'h00;
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h20 || uio_oe !== 8'hF0) begin
      errors++;
      $display("FAIL reset: got uo=%h uio=%h oe=%h need 00 20 f0", uo_out, uio_out, uio_oe);
    end
    uio_in[3] = 1'b1; #1;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL reset_hi: got uo=%h need 00", uo_out);
    end
    rst_n = 1'b0; clk_run = 1'b1;
  endtask

  task automatic test_seq(input string name, input logic [2:0] ops[4],
                          input logic [7:0] xs[4], input logic en);
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], xs[i], en, 1'b0);
      e = sb.pop_front();
      uio_in[3] = 1'b0; #1;
      checks++;
      if (uo_out !== e[7:0] || uio_out !== exp_flags(e)) begin
        errors++;
        $display("FAIL %s[%0d] lo: got uo=%h uio=%h need uo=%h uio=%h",
                 name, i, uo_out, uio_out, e[7:0], exp_flags(e));
      end
      uio_in[3] = 1'b1; #1;
      checks++;
      if (uo_out !== e[15:8]) begin
        errors++;
        $display("FAIL %s[%0d] hi: got uo=%h need uo=%h", name, i, uo_out, e[15:8]);
      end
    end
  endtask

  task automatic test_load_add;
    test_seq("load_add", '{3'd3, 3'd4, 3'd1, 3'd0}, '{8'h34, 8'h12, 8'hCC, 8'h00}, 1'b1);
    checks++;
    if (m_acc !== 16'h1300 || m_c !== 1'b0) begin
      errors++; $display("FAIL load_add_model: got %h c=%b need 1300 c=0", m_acc, m_c);
    end
  endtask

  task automatic test_wrap;
    test_seq("wrap_add", '{3'd3, 3'd4, 3'd1, 3'd7}, '{8'hFF, 8'hFF, 8'h01, 8'h55}, 1'b1);
    test_seq("ovf_add", '{3'd3, 3'd4, 3'd1, 3'd0}, '{8'hFF, 8'h7F, 8'h01, 8'h00}, 1'b1);
    test_seq("sub_adds", '{3'd5, 3'd2, 3'd6, 3'd3}, '{8'h00, 8'h01, 8'h81, 8'h10}, 1'b1);
  endtask

  task automatic test_ena;
    test_seq("ena_off", '{3'd1, 3'd1, 3'd1, 3'd5}, '{8'h05, 8'h05, 8'h05, 8'h00}, 1'b0);
  endtask

  task automatic test_back_to_back;
    test_seq("b2b_add", '{3'd1, 3'd1, 3'd1, 3'd1}, '{8'hCC, 8'hCC, 8'hCC, 8'hCC}, 1'b1);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] o[4];
      logic [7:0] v[4];
      for (int j = 0; j < 4; j++) begin
        o[j] = 3'($urandom_range(0, 7)); v[j] = 8'($urandom);
      end
      test_seq("rand", o, v, 1'b1);
    end
  endtask

  task automatic test_mid_reset;
    drive(3'd3, 8'h40, 1'b1, 1'b0); void'(sb.pop_front());
    drive(3'd1, 8'h05, 1'b1, 1'b0); void'(sb.pop_front());
    rst_n = 1'b1; uio_in[3] = 1'b0; #1;
    m_acc = 16'h0; m_c = 1'b0; m_v = 1'b0;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h20) begin
      errors++; $display("FAIL mid_reset: got uo=%h uio=%h need 00 20", uo_out, uio_out);
    end
    drive(3'd1, 8'h05, 1'b1, 1'b1);
    e = sb.pop_front();
    uio_in[3] = 1'b0; #1;
    checks++;
    if (uo_out !== e[7:0] || uio_out !== exp_flags(e)) begin
      errors++; $display("FAIL reset_held: got uo=%h uio=%h need %h %h",
                         uo_out, uio_out, e[7:0], exp_flags(e));
    end
    test_seq("after_release", '{3'd1, 3'd0, 3'd1, 3'd2}, '{8'h05, 8'h00, 8'h05, 8'h0B}, 1'b1);
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_wrap();
    test_ena();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
